// File: rtl/hwmod_rst_seq_if.sv
// Signal bundle between the hwmod violation monitors / core and the reset sequencer.
// The master side drives the violation pulses, pc and cause_clr. The slave side is the sequencer.
interface hwmod_rst_seq_if #(
  parameter int CNT_W = 8
);
  logic             vrased_viol;
  logic             casu_viol;
  logic             garota_viol;
  logic [15:0]      pc;
  logic             cause_clr;
  logic             core_rst;
  logic             seq_busy;
  logic [3:0]       viol_cause;
  logic [CNT_W-1:0] viol_count;

  modport master (
    output vrased_viol, casu_viol, garota_viol, pc, cause_clr,
    input  core_rst, seq_busy, viol_cause, viol_count
  );

  modport slave (
    input  vrased_viol, casu_viol, garota_viol, pc, cause_clr,
    output core_rst, seq_busy, viol_cause, viol_count
  );
endinterface

// File: rtl/hwmod_rst_seq.sv
// Reset sequencer: stretches violation pulses into a fixed-length core reset, then waits for pc
// to reach the reset handler. The cause/count logging is built only when HWMOD_RST_LOG_EN is defined.
module hwmod_rst_seq #(
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int          RST_HOLD      = 8,
  parameter int          WAIT_TIMEOUT  = 16'h0100,
  parameter int          CNT_W         = 8
) (
  input  logic           clk,
  input  logic           reset,
  hwmod_rst_seq_if.slave bus
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, HOLD, WAIT_HANDLER} state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              core_rst_q, seq_busy_q;
  logic [2:0]        viol_bits;
  logic              viol;

  assign viol_bits = {bus.garota_viol, bus.casu_viol, bus.vrased_viol};
  assign viol      = |viol_bits;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      wait_cnt_q <= '0;
      core_rst_q <= 1'b1;
      seq_busy_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      core_rst_q <= (state_d == HOLD);
      seq_busy_q <= (state_d != RUN);
    end
  end

  // A violation always wins: it restarts HOLD, then pc match, then the timeout.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (viol) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      HOLD: begin
        if (viol) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = WAIT_HANDLER;
          wait_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      WAIT_HANDLER: begin
        if (viol) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end else if (bus.pc == RESET_HANDLER) begin
          state_d = RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = HOLD;
        hold_cnt_d = '0;
      end
    endcase
  end

  assign bus.core_rst = core_rst_q;
  assign bus.seq_busy = seq_busy_q;

`ifdef HWMOD_RST_LOG_EN
  logic [3:0]       viol_cause_q;
  logic [CNT_W-1:0] viol_count_q;
  logic             cnt_inc;
  logic             timeout_hit;
  logic             cause_wipe;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (val == {CNT_W{1'b1}}) ? val : val + 1'b1;
  endfunction

  // Only a violation that leaves RUN or WAIT_HANDLER counts as a new event.
  always_comb begin
    cnt_inc     = viol && (state_q == RUN || state_q == WAIT_HANDLER);
    timeout_hit = !viol && (state_q == WAIT_HANDLER) && (state_d == HOLD);
    cause_wipe  = bus.cause_clr && (state_q == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      viol_cause_q <= '0;
      viol_count_q <= '0;
    end else begin
      viol_cause_q <= (cause_wipe ? 4'b0000 : viol_cause_q) | {timeout_hit, viol_bits};
      if (cnt_inc) viol_count_q <= sat_inc(viol_count_q);
    end
  end

  assign bus.viol_cause = viol_cause_q;
  assign bus.viol_count = viol_count_q;
`else
  assign bus.viol_cause = 4'b0000;
  assign bus.viol_count = '0;
`endif

endmodule

// File: tb/tb_hwmod_rst_seq.sv
// Bench for hwmod_rst_seq: a countdown-style behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations and a randomized phase.
module tb_hwmod_rst_seq;
  localparam int          RST_HOLD     = 8;
  localparam int          WAIT_TIMEOUT = 256;
  localparam int          CNT_W        = 8;
  localparam logic [15:0] RH           = 16'h0000;
`ifdef HWMOD_RST_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hwmod_rst_seq_if #(.CNT_W(CNT_W)) bus ();

  hwmod_rst_seq #(
    .RESET_HANDLER(RH),
    .RST_HOLD(RST_HOLD),
    .WAIT_TIMEOUT(WAIT_TIMEOUT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: hold_left = remaining core_rst cycles, waiting = watching pc, wait_age = cycles spent waiting.
  typedef struct {
    int         hold_left;
    bit         waiting;
    int         wait_age;
    logic [3:0] cause;
    int         count;
  } model_t;

  function automatic model_t m_reset();
    model_t m;
    m.hold_left = RST_HOLD;
    m.waiting   = 1'b0;
    m.wait_age  = 0;
    m.cause     = 4'b0000;
    m.count     = 0;
    return m;
  endfunction

  function automatic model_t m_step(model_t m, logic [2:0] v, logic [15:0] pc, logic clr);
    model_t n;
    bit     fire;
    n    = m;
    fire = 1'b0;
    if (m.hold_left > 0) begin
      if (|v) begin
        n.hold_left = RST_HOLD;
        n.cause     = n.cause | {1'b0, v};
      end else begin
        n.hold_left = m.hold_left - 1;
        if (n.hold_left == 0) begin
          n.waiting  = 1'b1;
          n.wait_age = 0;
        end
      end
    end else if (m.waiting) begin
      if (|v) fire = 1'b1;
      else if (pc == RH) n.waiting = 1'b0;
      else if (m.wait_age == WAIT_TIMEOUT - 1) begin
        n.waiting   = 1'b0;
        n.hold_left = RST_HOLD;
        n.cause[3]  = 1'b1;
      end else n.wait_age = m.wait_age + 1;
    end else begin
      if (clr) n.cause = 4'b0000;
      if (|v) fire = 1'b1;
    end
    if (fire) begin
      n.waiting   = 1'b0;
      n.hold_left = RST_HOLD;
      n.cause     = n.cause | {1'b0, v};
      if (n.count < (1 << CNT_W) - 1) n.count = n.count + 1;
    end
    if (!LOG) begin
      n.cause = 4'b0000;
      n.count = 0;
    end
    return n;
  endfunction

  model_t mdl;
  always @(posedge clk or posedge reset) begin
    if (reset) mdl <= m_reset();
    else mdl <= m_step(mdl, {bus.garota_viol, bus.casu_viol, bus.vrased_viol}, bus.pc, bus.cause_clr);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("core_rst", {31'b0, bus.core_rst}, {31'b0, mdl.hold_left > 0});
      chk("seq_busy", {31'b0, bus.seq_busy}, {31'b0, (mdl.hold_left > 0) || mdl.waiting});
      chk("viol_cause", {28'b0, bus.viol_cause}, {28'b0, mdl.cause});
      chk("viol_count", {24'b0, bus.viol_count}, mdl.count);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_hi(output int n);
    n = 0;
    while (bus.core_rst === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_lo(output int n);
    n = 0;
    while (bus.core_rst === 1'b0 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_run();
    int k;
    k = 0;
    while (bus.seq_busy !== 1'b0 && k < 2000) begin
      k++;
      @(negedge clk);
    end
    chk("wait_run_bound", {31'b0, k < 2000}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int mode;
    bus.vrased_viol = 1'b0;
    bus.casu_viol   = 1'b0;
    bus.garota_viol = 1'b0;
    bus.pc          = 16'hFFFF;
    bus.cause_clr   = 1'b0;
    reset           = 1'b1;
    cyc(2);
    cmp_en = 1'b1;
    cyc(1);
    chk("rst_core_rst", {31'b0, bus.core_rst}, 32'd1);
    chk("rst_seq_busy", {31'b0, bus.seq_busy}, 32'd1);
    chk("rst_cause", {28'b0, bus.viol_cause}, 32'd0);
    chk("rst_count", {24'b0, bus.viol_count}, 32'd0);

    // Reset release: 8 cycles of core_rst, then pc already at the handler.
    bus.pc = 16'h0000;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    count_hi(n);
    chk("t1_hold_len", n, 32'd8);
    cyc(1);
    chk("t1_busy", {31'b0, bus.seq_busy}, 32'd0);
    chk("t1_count", {24'b0, bus.viol_count}, 32'd0);

    // Single casu pulse in RUN.
    bus.casu_viol = 1'b1;
    cyc(1);
    bus.casu_viol = 1'b0;
    count_hi(n);
    chk("t2_hold_len", n, 32'd8);
    cyc(1);
    chk("t2_busy", {31'b0, bus.seq_busy}, 32'd0);
    chk("t2_cause", {28'b0, bus.viol_cause}, LOG ? 32'h2 : 32'h0);
    chk("t2_count", {24'b0, bus.viol_count}, LOG ? 32'd1 : 32'd0);

    // vrased, then garota three cycles later while holding.
    bus.cause_clr = 1'b1;
    cyc(1);
    bus.cause_clr   = 1'b0;
    bus.vrased_viol = 1'b1;
    cyc(1);
    bus.vrased_viol = 1'b0;
    cyc(2);
    bus.garota_viol = 1'b1;
    cyc(1);
    bus.garota_viol = 1'b0;
    count_hi(n);
    chk("t3_hold_len", n + 3, 32'd11);
    chk("t3_cause", {28'b0, bus.viol_cause}, LOG ? 32'h5 : 32'h0);
    chk("t3_count", {24'b0, bus.viol_count}, LOG ? 32'd2 : 32'd0);

    // Handler never reached: timeout after WAIT_TIMEOUT cycles.
    bus.pc = 16'h1234;
    count_lo(n);
    chk("t4_wait_len", n, 32'd256);
    chk("t4_cause", {28'b0, bus.viol_cause}, LOG ? 32'hD : 32'h0);
    chk("t4_count", {24'b0, bus.viol_count}, LOG ? 32'd2 : 32'd0);
    bus.pc = 16'h0000;
    count_hi(n);
    chk("t4_rehold_len", n, 32'd8);
    wait_run();

    // Drive the count up to saturation, then one more event.
    for (int i = 0; i < 253; i++) begin
      bus.casu_viol = 1'b1;
      cyc(1);
      bus.casu_viol = 1'b0;
      wait_run();
    end
    chk("t5_count_full", {24'b0, bus.viol_count}, LOG ? 32'd255 : 32'd0);
    bus.casu_viol = 1'b1;
    cyc(1);
    bus.casu_viol = 1'b0;
    wait_run();
    chk("t5_count_sat", {24'b0, bus.viol_count}, LOG ? 32'd255 : 32'd0);
    bus.cause_clr   = 1'b1;
    bus.garota_viol = 1'b1;
    cyc(1);
    bus.cause_clr   = 1'b0;
    bus.garota_viol = 1'b0;
    chk("t5_clr_cause", {28'b0, bus.viol_cause}, LOG ? 32'h4 : 32'h0);
    chk("t5_clr_count", {24'b0, bus.viol_count}, LOG ? 32'd255 : 32'd0);
    wait_run();

    // Asynchronous reset in the middle of a hold.
    bus.vrased_viol = 1'b1;
    cyc(1);
    bus.vrased_viol = 1'b0;
    cyc(3);
    #2 reset = 1'b1;
    #1;
    chk("arst_core_rst", {31'b0, bus.core_rst}, 32'd1);
    chk("arst_busy", {31'b0, bus.seq_busy}, 32'd1);
    chk("arst_cause", {28'b0, bus.viol_cause}, 32'd0);
    chk("arst_count", {24'b0, bus.viol_count}, 32'd0);
    cyc(2);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_run();

    // Randomized phase: alternate pc-friendly blocks with blocks that force timeouts.
    for (int b = 0; b < 12; b++) begin
      mode = b % 2;
      for (int i = 0; i < 300; i++) begin
        if (mode == 0) begin
          bus.vrased_viol = ($urandom_range(0, 19) == 0);
          bus.casu_viol   = ($urandom_range(0, 19) == 0);
          bus.garota_viol = ($urandom_range(0, 19) == 0);
          bus.pc          = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
        end else begin
          bus.vrased_viol = ($urandom_range(0, 999) == 0);
          bus.casu_viol   = ($urandom_range(0, 999) == 0);
          bus.garota_viol = ($urandom_range(0, 999) == 0);
          bus.pc          = 16'($urandom) | 16'h0001;
        end
        bus.cause_clr = ($urandom_range(0, 7) == 0);
        cyc(1);
      end
    end

    bus.vrased_viol = 1'b0;
    bus.casu_viol   = 1'b0;
    bus.garota_viol = 1'b0;
    bus.cause_clr   = 1'b0;
    bus.pc          = 16'h0000;
    wait_run();
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
